// File: rtl/zap_wb_drain.sv
// Drains a FWFT write/read FIFO onto a Wishbone B3 classic master bus.
// Latency: pop is combinational with head valid, CYC rises one cycle later; reads return one cycle after ACK.
// Backpressure: the bus holds each beat until ACK/ERR and pops only then; bursts cap at MAX_BURST beats.
//
// Ports:
//   i_clk, i_reset              clock, async active-high reset
//   i_fifo_data/_empty_n        FIFO head {we, sel[3:0], adr[31:0], dat[31:0]} and its valid
//   o_fifo_ack                  pop strobe for the FIFO head
//   o_wb_*                      registered Wishbone master outputs
//   i_wb_ack/_err/_dat          slave response
//   o_rd_valid/o_rd_data        one-cycle read return
//   o_err/o_err_adr             sticky bus error and address of the first erroring beat
//   o_busy                      FSM not in IDLE
module zap_wb_drain #(
  parameter int unsigned MAX_BURST = 32'd8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [68:0] i_fifo_data,
  input  logic        i_fifo_empty_n,
  output logic        o_fifo_ack,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_dat,
  output logic        o_rd_valid,
  output logic [31:0] o_rd_data,
  output logic        o_err,
  output logic [31:0] o_err_adr,
  output logic        o_busy
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        err_q, err_d;
  logic [31:0] err_adr_q, err_adr_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        pop;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    err_adr_d  = err_adr_q;
    beat_cnt_d = beat_cnt_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_fifo_empty_n) begin
          pop                           = 1'b1;
          {we_d, sel_d, adr_d, dat_d}   = i_fifo_data;
          cyc_d                         = 1'b1;
          stb_d                         = 1'b1;
          beat_cnt_d                    = 8'd1;
          state_d                       = BUS;
        end
      end

      BUS: begin
        // ERR wins over a simultaneous ACK; the errored beat is dropped, never replayed.
        if (i_wb_err) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          if (!err_q) begin
            err_adr_d = adr_q;
          end
          state_d = GAP;
        end else if (i_wb_ack) begin
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = i_wb_dat;
          end
          // Chain the next entry into the same cycle so CYC never dips inside a burst.
          if (i_fifo_empty_n && (beat_cnt_q < MAX_B)) begin
            pop                         = 1'b1;
            {we_d, sel_d, adr_d, dat_d} = i_fifo_data;
            beat_cnt_d                  = beat_cnt_q + 8'd1;
          end else begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'd0;
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
      err_q      <= 1'b0;
      err_adr_q  <= 32'd0;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      err_adr_q  <= err_adr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Reset forces IDLE asynchronously, so the pop must also be gated by reset itself.
  assign o_fifo_ack = pop & ~i_reset;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = stb_q;
  assign o_wb_we    = we_q;
  assign o_wb_sel   = sel_q;
  assign o_wb_adr   = adr_q;
  assign o_wb_dat   = dat_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
  assign o_err      = err_q;
  assign o_err_adr  = err_adr_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_zap_wb_drain.sv
// Self-checking bench for zap_wb_drain: FIFO + slave models, scoreboard of issued entries,
// and a negedge monitor that checks every bus beat and the burst/gap rules.
module tb_zap_wb_drain;

  localparam int MAXB = 8;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [68:0] i_fifo_data;
  logic        i_fifo_empty_n;
  logic        o_fifo_ack;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic        i_wb_ack, i_wb_err;
  logic [31:0] i_wb_dat;
  logic        o_rd_valid;
  logic [31:0] o_rd_data;
  logic        o_err;
  logic [31:0] o_err_adr;
  logic        o_busy;

  always #5 i_clk = ~i_clk;

  zap_wb_drain #(.MAX_BURST(MAXB)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_fifo_data(i_fifo_data), .i_fifo_empty_n(i_fifo_empty_n), .o_fifo_ack(o_fifo_ack),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_err(o_err), .o_err_adr(o_err_adr), .o_busy(o_busy)
  );

  int tests = 0;
  int fails = 0;

  logic [68:0] fifo_q[$];      // upstream FIFO contents
  logic [68:0] exp_beat_q[$];  // scoreboard: beats the bus must still present, in order
  logic [31:0] err_adrs[$];    // slave answers ERR at these addresses
  int          pops = 0;

  int          fixed_wait = 0;
  int          beat_wait  = 0;
  int          wait_cnt   = 0;
  bit          rand_wait  = 0;
  int          err_pct    = 0;
  bit          rdata_fixed_en = 0;
  logic [31:0] rdata_fixed = '0;

  bit cyc_trace[$];
  int runs_q[$];
  int gaps_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_err_adr(input logic [31:0] a);
    foreach (err_adrs[i]) if (err_adrs[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_wait(input int w);
    fixed_wait = w;
    beat_wait  = w;
    wait_cnt   = 0;
  endtask

  task automatic push(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    fifo_q.push_back({we, sel, adr, dat});
    exp_beat_q.push_back({we, sel, adr, dat});
    i_fifo_empty_n = 1'b1;
    i_fifo_data    = fifo_q[0];
  endtask

  task automatic push_rand();
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    we  = 1'($urandom_range(0, 1));
    sel = 4'($urandom_range(0, 15));
    adr = $urandom();
    dat = $urandom();
    push(we, sel, adr, dat);
  endtask

  // One clock: the pop is decided from o_fifo_ack sampled mid-cycle, then the FIFO
  // head and the slave response are refreshed just after the rising edge.
  task automatic step();
    logic        popped;
    logic [68:0] tmp;
    @(negedge i_clk);
    popped = o_fifo_ack;
    @(posedge i_clk);
    #1;
    if (popped && fifo_q.size() > 0) begin
      tmp = fifo_q.pop_front();
      pops++;
    end
    i_fifo_empty_n = (fifo_q.size() > 0);
    i_fifo_data    = (fifo_q.size() > 0) ? fifo_q[0] : 69'd0;
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    i_wb_dat = $urandom();
    if (o_wb_cyc && o_wb_stb) begin
      if (wait_cnt >= beat_wait) begin
        if (is_err_adr(o_wb_adr) || ($urandom_range(0, 99) < err_pct)) begin
          i_wb_err = 1'b1;
          i_wb_ack = 1'($urandom_range(0, 1));
        end else begin
          i_wb_ack = 1'b1;
        end
        if (rdata_fixed_en) i_wb_dat = rdata_fixed;
        wait_cnt  = 0;
        beat_wait = rand_wait ? $urandom_range(0, 2) : fixed_wait;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      cyc_trace.push_back(o_wb_cyc);
    end
  endtask

  // Splits the recorded CYC trace into burst lengths and the idle gaps between them.
  task automatic analyze();
    int r;
    int g;
    bit seen;
    r = 0; g = 0; seen = 0;
    runs_q.delete();
    gaps_q.delete();
    foreach (cyc_trace[i]) begin
      if (cyc_trace[i]) begin
        if (r == 0 && seen) gaps_q.push_back(g);
        r++;
        seen = 1;
      end else begin
        if (r > 0) begin
          runs_q.push_back(r);
          r = 0;
          g = 0;
        end
        g++;
      end
    end
    if (r > 0) runs_q.push_back(r);
  endtask

  task automatic wait_idle(input string name, input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (fifo_q.size() == 0 && !o_wb_cyc && !o_busy) begin
        ok = 1;
        break;
      end
      step();
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          m_cyc = 0;
  bit          m_gap = 0;
  int          m_beats = 0;
  bit          m_err = 0;
  logic [31:0] m_err_adr = '0;
  bit          rd_due = 0;
  logic [31:0] rd_exp = '0;
  bit          hold_chk = 0;
  logic [31:0] h_adr, h_dat;
  logic [3:0]  h_sel;
  logic        h_we;

  always @(negedge i_clk) begin
    logic [68:0] e;
    bit          exp_ack;
    bit          nxt_cyc;
    bit          nxt_gap;
    bit          resp;
    if (i_reset) begin
      check("rst_cyc", 32'(o_wb_cyc), 32'd0);
      check("rst_stb", 32'(o_wb_stb), 32'd0);
      check("rst_fifo_ack", 32'(o_fifo_ack), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);
      check("rst_rd_valid", 32'(o_rd_valid), 32'd0);
      m_cyc = 0; m_gap = 0; m_beats = 0; m_err = 0; m_err_adr = '0;
      rd_due = 0; hold_chk = 0;
    end else begin
      check("cyc_seq", 32'(o_wb_cyc), 32'(m_cyc));
      check("stb_seq", 32'(o_wb_stb), 32'(m_cyc));
      check("busy", 32'(o_busy), 32'(m_cyc | m_gap));
      if (!m_cyc) check("we_when_idle", 32'(o_wb_we), 32'd0);
      check("rd_valid", 32'(o_rd_valid), 32'(rd_due));
      if (rd_due) check("rd_data", o_rd_data, rd_exp);
      check("err_flag", 32'(o_err), 32'(m_err));
      check("err_adr", o_err_adr, m_err_adr);
      if (hold_chk) begin
        check("hold_adr", o_wb_adr, h_adr);
        check("hold_dat", o_wb_dat, h_dat);
        check("hold_sel", 32'(o_wb_sel), 32'(h_sel));
        if (m_cyc) check("hold_we", 32'(o_wb_we), 32'(h_we));
      end

      rd_due = 0; exp_ack = 0; nxt_cyc = 0; nxt_gap = 0; e = '0;
      resp = m_cyc && (i_wb_ack || i_wb_err);
      if (resp) begin
        if (exp_beat_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL beat_unexpected: bus beat adr 0x%08h with empty scoreboard", o_wb_adr);
        end else begin
          e = exp_beat_q.pop_front();
          check("beat_we", 32'(o_wb_we), 32'(e[68]));
          check("beat_sel", 32'(o_wb_sel), 32'(e[67:64]));
          check("beat_adr", o_wb_adr, e[63:32]);
          check("beat_dat", o_wb_dat, e[31:0]);
        end
      end

      if (m_gap) begin
        // one forced idle cycle after an error; no pop
      end else if (!m_cyc) begin
        exp_ack = i_fifo_empty_n;
        nxt_cyc = i_fifo_empty_n;
        m_beats = 0;
      end else if (i_wb_err) begin
        nxt_gap = 1;
        if (!m_err) begin
          m_err     = 1;
          m_err_adr = e[63:32];
        end
      end else if (i_wb_ack) begin
        m_beats++;
        exp_ack = i_fifo_empty_n && (m_beats < MAXB);
        nxt_cyc = exp_ack;
        if (!e[68]) begin
          rd_due = 1;
          rd_exp = i_wb_dat;
        end
      end else begin
        nxt_cyc = 1;
      end
      check("fifo_ack", 32'(o_fifo_ack), 32'(exp_ack));

      hold_chk = (m_cyc && !resp) || (!m_cyc && !exp_ack);
      h_adr = o_wb_adr; h_dat = o_wb_dat; h_sel = o_wb_sel; h_we = o_wb_we;
      m_cyc = nxt_cyc;
      m_gap = nxt_gap;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int rd_cnt;
    logic [31:0] rd_seen;

    i_reset = 1'b1;
    i_fifo_data = '0; i_fifo_empty_n = 1'b0;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_cyc", 32'(o_wb_cyc), 32'd0);
    check("reset_stb", 32'(o_wb_stb), 32'd0);
    check("reset_we", 32'(o_wb_we), 32'd0);
    check("reset_sel", 32'(o_wb_sel), 32'd0);
    check("reset_adr", o_wb_adr, 32'd0);
    check("reset_dat", o_wb_dat, 32'd0);
    check("reset_rd_valid", 32'(o_rd_valid), 32'd0);
    check("reset_rd_data", o_rd_data, 32'd0);
    check("reset_err", 32'(o_err), 32'd0);
    check("reset_err_adr", o_err_adr, 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_fifo_ack", 32'(o_fifo_ack), 32'd0);
    #2 i_reset = 1'b0;
    step(); step();

    // Single write, slave acks on the second BUS cycle.
    set_wait(1);
    p0 = pops;
    push(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
    cyc_trace.delete();
    step();
    cyc_trace.push_back(o_wb_cyc);
    check("t1_adr", o_wb_adr, 32'h100);
    check("t1_dat", o_wb_dat, 32'hDEAD_BEEF);
    check("t1_we_sel", {27'd0, o_wb_we, o_wb_sel}, {27'd0, 1'b1, 4'hF});
    record(5);
    analyze();
    check("t1_bursts", 32'(runs_q.size()), 32'd1);
    if (runs_q.size() > 0) check("t1_cyc_len", 32'(runs_q[0]), 32'd2);
    check("t1_pops", 32'(pops - p0), 32'd1);
    check("t1_idle", 32'(o_busy), 32'd0);

    // Ten entries, ack every cycle: 8-beat burst, one idle cycle, 2-beat burst.
    set_wait(0);
    p0 = pops;
    for (int i = 0; i < 10; i++) push(1'b1, 4'h3, 32'h1000 + 32'(i * 4), $urandom());
    cyc_trace.delete();
    record(16);
    analyze();
    check("t2_bursts", 32'(runs_q.size()), 32'd2);
    if (runs_q.size() == 2) begin
      check("t2_len0", 32'(runs_q[0]), 32'(MAXB));
      check("t2_len1", 32'(runs_q[1]), 32'd2);
    end
    if (gaps_q.size() > 0) check("t2_gap", 32'(gaps_q[0]), 32'd1);
    check("t2_pops", 32'(pops - p0), 32'd10);
    wait_idle("t2_drain", 50);

    // Read beat returns data one cycle after the ack.
    rdata_fixed_en = 1;
    rdata_fixed    = 32'h1234_5678;
    push(1'b0, 4'hF, 32'h40, 32'h0);
    rd_cnt = 0;
    rd_seen = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_rd_valid) begin
        rd_cnt++;
        rd_seen = o_rd_data;
      end
    end
    rdata_fixed_en = 0;
    check("t3_rd_count", 32'(rd_cnt), 32'd1);
    check("t3_rd_data", rd_seen, 32'h1234_5678);

    // Error on the middle of three entries.
    err_adrs.push_back(32'h08);
    p0 = pops;
    push(1'b1, 4'hF, 32'h04, 32'hA);
    push(1'b1, 4'hF, 32'h08, 32'hB);
    push(1'b1, 4'hF, 32'h10, 32'hC);
    cyc_trace.delete();
    record(12);
    analyze();
    check("t4_bursts", 32'(runs_q.size()), 32'd2);
    if (runs_q.size() == 2) begin
      check("t4_len0", 32'(runs_q[0]), 32'd2);
      check("t4_len1", 32'(runs_q[1]), 32'd1);
    end
    // GAP cycle, then the IDLE cycle that pops the third entry.
    if (gaps_q.size() > 0) check("t4_gap", 32'(gaps_q[0]), 32'd2);
    check("t4_pops", 32'(pops - p0), 32'd3);
    check("t4_err", 32'(o_err), 32'd1);
    check("t4_err_adr", o_err_adr, 32'h08);
    err_adrs.push_back(32'h0C);
    push(1'b1, 4'hF, 32'h0C, 32'hD);
    record(6);
    check("t4_err_sticky", 32'(o_err), 32'd1);
    check("t4_err_adr_kept", o_err_adr, 32'h08);
    err_adrs.delete();

    // Asynchronous reset mid-burst.
    set_wait(5);
    p0 = pops;
    push(1'b1, 4'h1, 32'h200, 32'h11);
    push(1'b1, 4'h2, 32'h204, 32'h22);
    push(1'b0, 4'h4, 32'h208, 32'h33);
    step(); step();
    check("t5_in_bus", 32'(o_wb_cyc), 32'd1);
    #2 i_reset = 1'b1;
    exp_beat_q = fifo_q;  // in-flight beat is lost, queued ones remain
    #1;
    check("t5_async_cyc", 32'(o_wb_cyc), 32'd0);
    check("t5_async_stb", 32'(o_wb_stb), 32'd0);
    check("t5_async_ack", 32'(o_fifo_ack), 32'd0);
    check("t5_err_cleared", 32'(o_err), 32'd0);
    step(); step();
    check("t5_no_pop_in_reset", 32'(pops - p0), 32'd1);
    #2 i_reset = 1'b0;
    wait_idle("t5_drain", 100);
    check("t5_pops", 32'(pops - p0), 32'd3);
    check("t5_scoreboard", 32'(exp_beat_q.size()), 32'd0);

    // FIFO empties exactly at the ack; later entry starts a fresh burst.
    set_wait(0);
    p0 = pops;
    push(1'b1, 4'h8, 32'h300, 32'h44);
    cyc_trace.delete();
    record(4);
    analyze();
    check("t6_first_len", 32'(runs_q.size() > 0 ? runs_q[0] : 0), 32'd1);
    step(); step(); step();
    push(1'b1, 4'h8, 32'h304, 32'h55);
    cyc_trace.delete();
    record(4);
    analyze();
    check("t6_second_bursts", 32'(runs_q.size()), 32'd1);
    check("t6_pops", 32'(pops - p0), 32'd2);

    // Randomized traffic: random waits, errors, ack+err collisions, bursty pushes.
    rand_wait = 1;
    err_pct   = 6;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 35) push_rand();
      if ($urandom_range(0, 99) < 4) begin
        for (int k = 0; k < 9; k++) push_rand();
      end
      step();
    end
    wait_idle("rand_drain", 4000);
    rand_wait = 0;
    err_pct   = 0;
    step(); step();

    check("scoreboard_empty", 32'(exp_beat_q.size()), 32'd0);
    check("fifo_drained", 32'(fifo_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zap_wb_drain.md
ZAP_WB_DRAIN -- requirements
Module: zap_wb_drain

Interface
REQ-001 SHALL have parameter MAX_BURST, default 32'd8: maximum FIFO entries issued under one held CYC; legal range 1..255.
REQ-002 SHALL have port i_clk, input, 1: the single clock, all state on its rising edge.
REQ-003 SHALL have port i_reset, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port i_fifo_data, input, 69: head entry of upstream zap_sync_fifo (FWFT), packed as {we[68], sel[67:64], addr[63:32], data[31:0]}.
REQ-005 SHALL have port i_fifo_empty_n, input, 1: head entry valid.
REQ-006 SHALL have port o_fifo_ack, output, 1: pops the head entry; combinational.
REQ-007 SHALL have ports o_wb_cyc, o_wb_stb, o_wb_we (output, 1 each), o_wb_sel (output, 4), o_wb_adr and o_wb_dat (output, 32 each): Wishbone B3 classic master, all registered.
REQ-008 SHALL have ports i_wb_ack, i_wb_err (input, 1 each) and i_wb_dat (input, 32): slave response.
REQ-009 SHALL have ports o_rd_valid (output, 1) and o_rd_data (output, 32): read return, registered.
REQ-010 SHALL have ports o_err (output, 1), sticky bus-error flag, and o_err_adr (output, 32), address of the first erroring beat.
REQ-011 SHALL have port o_busy, output, 1: high when state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, BUS, GAP.
REQ-013 IDLE: when i_fifo_empty_n=1, SHALL assert o_fifo_ack, latch the entry into the WB output registers, set cyc=stb=1, set beat_cnt=1, and go to BUS the next cycle; zero-cycle latency from valid to pop, one cycle to CYC.
REQ-014 BUS: SHALL hold every WB output stable until i_wb_ack or i_wb_err is high.
REQ-015 BUS, i_wb_ack=1, i_fifo_empty_n=1, beat_cnt<MAX_BURST: SHALL pop and latch the next entry in the same cycle, keep cyc=stb=1, increment beat_cnt, and stay in BUS (back-to-back, no bubble).
REQ-016 BUS, i_wb_ack=1, and either the FIFO is empty or beat_cnt=MAX_BURST: SHALL clear cyc and stb next cycle and go to IDLE.
REQ-017 BUS, i_wb_err=1: SHALL clear cyc and stb, set o_err=1, load o_err_adr only if o_err was 0, issue no pop, and go to GAP.
REQ-018 i_wb_ack and i_wb_err both high SHALL be treated as err only.
REQ-019 GAP SHALL last exactly one cycle with cyc=0 and then go to IDLE; IDLE likewise forces at least one cyc=0 cycle between bursts.
REQ-020 A read beat (we=0) acked SHALL produce o_rd_valid=1 for exactly one cycle, the cycle after the ack, with o_rd_data=i_wb_dat captured at the ack; an errored read SHALL NOT assert o_rd_valid.
REQ-021 o_fifo_ack SHALL never be asserted when i_fifo_empty_n=0, and at most once per WB beat.
REQ-022 beat_cnt SHALL be 8 bits and SHALL NOT wrap; it is reloaded to 1 at each burst start.
REQ-023 o_err SHALL clear only on reset.
REQ-024 While cyc=0, o_wb_stb and o_wb_we SHALL be 0; adr, dat and sel keep their last values.

Reset
REQ-025 While i_reset is high, independent of the clock: state=IDLE, o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_sel=0, o_wb_adr=o_wb_dat=0, o_rd_valid=0, o_rd_data=0, o_err=0, o_err_adr=0, beat_cnt=0, and o_fifo_ack=0.
REQ-026 Reset asserted mid-burst SHALL drop CYC immediately and lose the in-flight beat; the entry already popped is not replayed.
REQ-027 After reset deasserts, the first pop SHALL occur no earlier than the first rising edge following deassertion.

Verification
REQ-028 One write entry {1,4'hF,32'h100,32'hDEAD_BEEF}, slave acks on the 2nd BUS cycle -> one pop; cyc high for 2 cycles with adr 0x100 and dat 0xDEADBEEF; then idle.
REQ-029 Ten entries pre-loaded, MAX_BURST=8, slave acks every cycle -> 8 beats with cyc held, then cyc=0 for 1 cycle, then 2 beats; exactly 10 pops.
REQ-030 Read entry to addr 0x40, slave returns 0x1234_5678 with ack -> o_rd_valid one cycle later with o_rd_data=0x12345678.
REQ-031 Error on the 2nd of 3 entries (addr 0x08) -> o_err=1, o_err_adr=0x08, cyc dropped, GAP of one cycle, 3rd entry issued as a new burst; a later error at 0x0C leaves o_err_adr=0x08.
REQ-032 Reset asserted asynchronously mid-BUS -> cyc=stb=0 before the next clock edge; no pop during reset; after release, queued entries drain normally.
REQ-033 FIFO goes empty exactly at an ack -> no pop, cyc=0 next cycle; an entry arriving later starts a new burst from IDLE.
